// File: rtl/duty_ramp_ctrl_if.sv
// Signal bundle between the switch/LED board logic and the duty ramp controller.
interface duty_ramp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Switches;
  logic             Hold;
  logic [WIDTH-1:0] Duty;
  logic             PeriodStart;
  logic             Ramping;
  logic             AtTarget;

  modport master (
    output Switches, Hold,
    input  Duty, PeriodStart, Ramping, AtTarget
  );

  modport slave (
    input  Switches, Hold,
    output Duty, PeriodStart, Ramping, AtTarget
  );
endinterface

// File: rtl/duty_ramp_ctrl.sv
// Debounces the slide switches into a target duty and slews Duty toward it
// one LSB at a time, only ever changing it on PWM-period boundaries.
module duty_ramp_ctrl #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1000000,
  parameter int STEP_PERIODS  = 4
) (
  input logic              Clock,
  input logic              Reset_n,
  duty_ramp_ctrl_if.slave  bus
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);
  localparam logic [WIDTH-1:0]  PER_LAST  = '1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;

  logic [WIDTH-1:0]  r_syncMeta;
  logic [WIDTH-1:0]  r_sync;
  logic [WIDTH-1:0]  r_cand;
  logic [STAB_W-1:0] r_stabCnt;
  logic [WIDTH-1:0]  r_target;
  logic [WIDTH-1:0]  r_perCnt;
  logic              r_periodStart;
  logic [0:0]        r_state;
  logic [STEP_W-1:0] r_stepCnt;
  logic [WIDTH-1:0]  r_duty;
  logic              r_ramping;
  logic              r_atTarget;

  logic              w_tick;
  logic [WIDTH-1:0]  w_dutyNext;

  assign w_tick     = (r_perCnt == PER_LAST);
  assign w_dutyNext = (r_target > r_duty) ? (r_duty + WIDTH'(1)) : (r_duty - WIDTH'(1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_syncMeta <= '0;
      r_sync     <= '0;
    end else begin
      r_syncMeta <= bus.Switches;
      r_sync     <= r_syncMeta;
    end
  end

  // Any disagreement restarts the stability window; once full, target is reloaded every cycle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cand    <= '0;
      r_stabCnt <= '0;
      r_target  <= '0;
    end else if (r_sync != r_cand) begin
      r_cand    <= r_sync;
      r_stabCnt <= '0;
    end else if (r_stabCnt == STAB_LAST) begin
      r_target  <= r_cand;
    end else begin
      r_stabCnt <= r_stabCnt + STAB_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_perCnt      <= '0;
      r_periodStart <= 1'b0;
    end else begin
      r_perCnt      <= r_perCnt + WIDTH'(1);
      r_periodStart <= w_tick;
    end
  end

  // Duty is written only on the tick edge so the new value lands with PeriodStart.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ST_IDLE;
      r_stepCnt <= '0;
      r_duty    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (r_target != r_duty) begin
        r_state   <= ST_RAMP;
        r_stepCnt <= '0;
      end
    end else begin
      if (r_target == r_duty) begin
        r_state <= ST_IDLE;
      end else if (w_tick && !bus.Hold) begin
        if (r_stepCnt != STEP_LAST) begin
          r_stepCnt <= r_stepCnt + STEP_W'(1);
        end else begin
          r_stepCnt <= '0;
          r_duty    <= w_dutyNext;
          if (w_dutyNext == r_target) begin
            r_state <= ST_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ramping  <= 1'b0;
      r_atTarget <= 1'b1;
    end else begin
      r_ramping  <= (r_state == ST_RAMP);
      r_atTarget <= (r_state == ST_IDLE);
    end
  end

  assign bus.Duty        = r_duty;
  assign bus.PeriodStart = r_periodStart;
  assign bus.Ramping     = r_ramping;
  assign bus.AtTarget    = r_atTarget;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Self-checking bench for duty_ramp_ctrl: cycle-by-cycle reference model plus
// a vector table and hand-written multi-cycle scenarios.
module tb_duty_ramp_ctrl;

  localparam int WIDTH         = 8;
  localparam int STABLE_CYCLES = 8;
  localparam int STEP_PERIODS  = 2;
  localparam int PERIOD        = 1 << WIDTH;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b1;

  duty_ramp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  duty_ramp_ctrl #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES),
    .STEP_PERIODS  (STEP_PERIODS)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [WIDTH-1:0] sw;
    logic             hold;
    int               cycles;
    logic [WIDTH-1:0] expDuty;
    logic             expAtTarget;
  } vec_t;

  vec_t vecs[7];

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: sampled switch history, target, duty, ramp flag.
  int               cyc;
  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] mTarget;
  logic [WIDTH-1:0] mDuty;
  bit               mRamp;
  int               mTicks;
  bit               mPs;
  bit               mRampOut;
  bit               mAtOut;

  task automatic checkValue(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string name);
    logic [WIDTH+2:0] act;
    logic [WIDTH+2:0] exp;
    act = {bus.Duty, bus.PeriodStart, bus.Ramping, bus.AtTarget};
    exp = {mDuty, mPs, mRampOut, mAtOut};
    checkValue(name, int'(act), int'(exp));
  endtask

  task automatic modelReset();
    cyc = 0;
    hist.delete();
    repeat (3) hist.push_back('0);
    mTarget  = '0;
    mDuty    = '0;
    mRamp    = 1'b0;
    mTicks   = 0;
    mPs      = 1'b0;
    mRampOut = 1'b0;
    mAtOut   = 1'b1;
  endtask

  // Target follows the switch value once it has been seen unchanged for
  // STABLE_CYCLES+1 consecutive samples, two samples behind the input.
  task automatic modelEdge(input logic [WIDTH-1:0] sw, input logic hold);
    bit               tick;
    int               n;
    int               run;
    logic [WIDTH-1:0] newTarget;
    tick = ((cyc % PERIOD) == PERIOD - 1);
    hist.push_back(sw);
    if (hist.size() > STABLE_CYCLES + 4) void'(hist.pop_front());
    n   = hist.size();
    run = 1;
    for (int k = n - 4; k >= 0 && hist[k] == hist[n-3]; k--) run++;
    newTarget = (run >= STABLE_CYCLES + 1) ? hist[n-3] : mTarget;
    mPs      = tick;
    mRampOut = mRamp;
    mAtOut   = !mRamp;
    if (!mRamp) begin
      if (mTarget != mDuty) begin
        mRamp  = 1'b1;
        mTicks = 0;
      end
    end else if (mTarget == mDuty) begin
      mRamp = 1'b0;
    end else if (tick && !hold) begin
      mTicks++;
      if (mTicks % STEP_PERIODS == 0) begin
        mDuty = (mTarget > mDuty) ? mDuty + 1'b1 : mDuty - 1'b1;
        if (mDuty == mTarget) mRamp = 1'b0;
      end
    end
    mTarget = newTarget;
    cyc++;
  endtask

  task automatic cycleStep();
    if (Reset_n) modelEdge(bus.Switches, bus.Hold);
    @(posedge Clock);
    #1;
    checkOutput("cycleOutputs");
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] sw, input logic hold, input int n);
    bus.Switches = sw;
    bus.Hold     = hold;
    repeat (n) cycleStep();
  endtask

  task automatic resetDut(input logic [WIDTH-1:0] sw);
    Reset_n      = 1'b0;
    modelReset();
    bus.Switches = sw;
    bus.Hold     = 1'b0;
    repeat (5) cycleStep();
    Reset_n = 1'b1;
  endtask

  task automatic waitPs(input int maxCycles, output int cnt, output bit ok);
    ok  = 1'b0;
    cnt = 0;
    for (int i = 0; i < maxCycles; i++) begin
      cycleStep();
      cnt++;
      if (bus.PeriodStart) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitDuty(input logic [WIDTH-1:0] val, input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      cycleStep();
      if (bus.Duty == val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #950000;
    nFails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int               cnt;
    bit               ok;
    bit               flag;
    logic [WIDTH-1:0] prev;
    int               steps[$];

    vecs[0] = '{sw: 8'h02, hold: 1'b0, cycles: 1600, expDuty: 8'h02, expAtTarget: 1'b1};
    vecs[1] = '{sw: 8'h00, hold: 1'b1, cycles: 1200, expDuty: 8'h02, expAtTarget: 1'b0};
    vecs[2] = '{sw: 8'h00, hold: 1'b0, cycles: 1300, expDuty: 8'h00, expAtTarget: 1'b1};
    vecs[3] = '{sw: 8'h05, hold: 1'b0, cycles: 300,  expDuty: 8'h00, expAtTarget: 1'b0};
    vecs[4] = '{sw: 8'h00, hold: 1'b0, cycles: 50,   expDuty: 8'h00, expAtTarget: 1'b1};
    vecs[5] = '{sw: 8'hFF, hold: 1'b1, cycles: 400,  expDuty: 8'h00, expAtTarget: 1'b0};
    vecs[6] = '{sw: 8'h00, hold: 1'b1, cycles: 100,  expDuty: 8'h00, expAtTarget: 1'b1};

    bus.Switches = 8'hFF;
    bus.Hold     = 1'b0;
    modelReset();
    #2;

    $display("[TB] reset and period counter");
    resetDut(8'hFF);
    checkValue("resetDuty", int'(bus.Duty), 0);
    checkValue("resetRamping", int'(bus.Ramping), 0);
    checkValue("resetAtTarget", int'(bus.AtTarget), 1);
    checkValue("resetPeriodStart", int'(bus.PeriodStart), 0);
    bus.Switches = 8'h00;
    waitPs(300, cnt, ok);
    checkValue("firstPeriodStartDelay", cnt, PERIOD);
    waitPs(300, cnt, ok);
    checkValue("secondPeriodStartDelay", cnt, PERIOD);

    $display("[TB] up-ramp");
    applyStimulus(8'h03, 1'b0, 12);
    checkValue("rampingBeforeEntry", int'(bus.Ramping), 0);
    cycleStep();
    checkValue("rampingAfterEntry", int'(bus.Ramping), 1);
    for (int p = 1; p <= 6; p++) begin
      waitPs(300, cnt, ok);
      checkValue("upRampPeriodSeen", int'(ok), 1);
      checkValue("upRampDuty", int'(bus.Duty), p / 2);
    end
    checkValue("upRampAtTargetLow", int'(bus.AtTarget), 0);
    cycleStep();
    checkValue("upRampAtTargetHigh", int'(bus.AtTarget), 1);

    $display("[TB] vector table");
    resetDut(8'h00);
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].sw, vecs[v].hold, vecs[v].cycles);
      checkValue("tableDuty", int'(bus.Duty), int'(vecs[v].expDuty));
      checkValue("tableAtTarget", int'(bus.AtTarget), int'(vecs[v].expAtTarget));
    end

    $display("[TB] bounce rejection");
    resetDut(8'h00);
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.Switches = (i % 2 == 0) ? 8'h10 : 8'h00;
      repeat (5) begin
        cycleStep();
        flag |= bus.Ramping;
      end
    end
    bus.Switches = 8'h00;
    repeat (50) begin
      cycleStep();
      flag |= bus.Ramping;
    end
    checkValue("bounceRampingSeen", int'(flag), 0);
    checkValue("bounceDuty", int'(bus.Duty), 0);

    $display("[TB] reversal");
    bus.Switches = 8'h0A;
    waitDuty(8'h05, 4000, ok);
    checkValue("reversalReachFive", int'(ok), 1);
    bus.Switches = 8'h03;
    prev = bus.Duty;
    ok   = 1'b0;
    steps.delete();
    for (int i = 0; i < 3000; i++) begin
      cycleStep();
      if (bus.Duty != prev) steps.push_back(int'(bus.Duty));
      prev = bus.Duty;
      if (bus.AtTarget && bus.Duty == 8'h03) begin
        ok = 1'b1;
        break;
      end
    end
    checkValue("reversalSettled", int'(ok), 1);
    checkValue("reversalStepCount", steps.size(), 2);
    checkValue("reversalFirstStep", (steps.size() > 0) ? steps[0] : -1, 4);
    checkValue("reversalSecondStep", (steps.size() > 1) ? steps[1] : -1, 3);

    bus.Switches = 8'h08;
    waitDuty(8'h05, 2000, ok);
    checkValue("reselectReachFive", int'(ok), 1);
    bus.Switches = 8'h05;
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycleStep();
      cnt++;
      if (bus.AtTarget) begin
        ok = 1'b1;
        break;
      end
    end
    checkValue("reselectIdleLatency", cnt, STABLE_CYCLES + 5);
    applyStimulus(8'h05, 1'b0, 1100);
    checkValue("reselectDutyKept", int'(bus.Duty), 5);

    $display("[TB] hold");
    resetDut(8'h00);
    bus.Switches = 8'h08;
    waitDuty(8'h02, 2000, ok);
    checkValue("holdReachTwo", int'(ok), 1);
    applyStimulus(8'h08, 1'b0, 300);
    bus.Hold = 1'b1;
    flag = 1'b1;
    repeat (1000) begin
      cycleStep();
      flag &= bus.Ramping;
    end
    checkValue("holdDutyFrozen", int'(bus.Duty), 2);
    checkValue("holdRampingKept", int'(flag), 1);
    bus.Hold = 1'b0;
    waitPs(300, cnt, ok);
    checkValue("holdReleasePeriodSeen", int'(ok), 1);
    checkValue("holdResumeStep", int'(bus.Duty), 3);

    $display("[TB] randomized segments");
    resetDut(8'h00);
    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < 6; b++) applyStimulus(WIDTH'($urandom_range(0, 6)), 1'b0, $urandom_range(1, 6));
      end
      applyStimulus(WIDTH'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0), $urandom_range(5, 700));
    end

    $display("[TB] async reset mid-ramp");
    resetDut(8'h00);
    bus.Switches = 8'h50;
    waitDuty(8'h40, 34000, ok);
    checkValue("asyncReachForty", int'(ok), 1);
    #2;
    Reset_n = 1'b0;
    modelReset();
    #1;
    checkValue("asyncResetDuty", int'(bus.Duty), 0);
    checkOutput("asyncResetOutputs");
    bus.Switches = 8'h40;
    repeat (3) cycleStep();
    Reset_n = 1'b1;
    waitDuty(8'h01, 1000, ok);
    checkValue("asyncRestartStep", int'(ok), 1);
    checkValue("asyncRestartDuty", int'(bus.Duty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
